// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among several masters.
// Ownership is held per Wishbone cycle, with outstanding-request tracking and a response timeout.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int GRANULE         = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 64,
    localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_stall_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_stall_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TERR,
        HOLD
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          rr_q;
    logic [OW-1:0]          outst_q;
    logic [TW-1:0]          timer_q;

    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          owner_next;
    logic [OW-1:0]          outst_next;
    logic                   full;
    logic                   accept;
    logic                   response;

    logic                   own_cyc;
    logic                   own_stb;
    logic                   own_we;
    logic [ADDR_WIDTH-1:0]  own_adr;
    logic [DATA_WIDTH-1:0]  own_dat;
    logic [SEL_WIDTH-1:0]   own_sel;

    // First requester at or above the rr pointer, wrapping past the top index.
    always_comb begin
        int unsigned idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!pick_valid && m_cyc_i[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (owner_q == IW'(k)) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                own_we  = m_we_i[k];
                own_adr = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                own_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                own_sel = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    assign owner_next = (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    assign full       = (outst_q == OW'(MAX_OUTSTANDING));

    assign s_we_o  = own_we;
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    // Responses arriving after the owner drops cyc are not forwarded.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        accept    = 1'b0;
        response  = 1'b0;
        case (state_q)
            GRANT: begin
                s_cyc_o            = own_cyc;
                s_stb_o            = own_stb & ~full;
                m_stall_o[owner_q] = s_stall_i | full;
                accept             = own_stb & ~(s_stall_i | full);
                response           = own_cyc & (s_ack_i | s_err_i);
                m_ack_o[owner_q]   = own_cyc & s_ack_i & ~s_err_i;
                m_err_o[owner_q]   = own_cyc & s_err_i;
            end
            TERR: begin
                m_err_o[owner_q] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        outst_next = outst_q;
        if (accept && !response) begin
            outst_next = outst_q + 1'b1;
        end else if (!accept && response && (outst_q != '0)) begin
            outst_next = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            outst_q <= '0;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    outst_q <= '0;
                    timer_q <= '0;
                    if (pick_valid) begin
                        state_q <= GRANT;
                        owner_q <= pick_idx;
                        grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
                    end
                end
                GRANT: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        rr_q    <= owner_next;
                        outst_q <= '0;
                        timer_q <= '0;
                    end else begin
                        outst_q <= outst_next;
                        if (response || (outst_q == '0)) begin
                            timer_q <= '0;
                        end else if (timer_q == TW'(TIMEOUT - 1)) begin
                            timer_q <= '0;
                            state_q <= TERR;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                TERR: begin
                    outst_q <= '0;
                    timer_q <= '0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        rr_q    <= owner_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: arbitration vector table, directed corner sequences,
// and randomized traffic compared against a behavioural reference model.
module tb_wb_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int MAXO = 4;
    localparam int TO   = 64;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_stall_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i, s_stall_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    wb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .GRANULE        (8),
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT        (TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_we_i   (m_we_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_stall_o(m_stall_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .s_stall_i(s_stall_i),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m_cyc_i   = '0;
        m_stb_i   = '0;
        m_we_i    = '0;
        m_adr_i   = '0;
        m_dat_i   = '0;
        m_sel_i   = '0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        s_stall_i = 1'b0;
        s_dat_i   = $urandom;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] cyc;
        logic [N-1:0] exp_grant;
    } arb_vec_t;

    arb_vec_t vecs[10];

    // Reference model: who owns the bus, the rr pointer, outstanding count, silent-cycle count.
    int mo_owner, mo_rr, mo_outs, mo_silent;
    bit mo_owned, mo_terr, mo_hold;
    logic [N-1:0] e_grant, e_ack, e_err, e_stall;
    logic e_busy, e_scyc, e_sstb;
    bit full, acc, resp;
    int o;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ack_cnt, stb_cnt, stall_cnt, j, hang;
        bit found;
        logic [N-1:0] nonown;

        vecs[0] = '{4'b0001, 4'b0001};
        vecs[1] = '{4'b0001, 4'b0001};
        vecs[2] = '{4'b1111, 4'b0010};
        vecs[3] = '{4'b1001, 4'b1000};
        vecs[4] = '{4'b0110, 4'b0010};
        vecs[5] = '{4'b0011, 4'b0001};
        vecs[6] = '{4'b1100, 4'b0100};
        vecs[7] = '{4'b0111, 4'b0001};
        vecs[8] = '{4'b1000, 4'b1000};
        vecs[9] = '{4'b0000, 4'b0000};

        // Reset values and a simple pipelined burst from master 0
        rst_i = 1'b0;
        idle_inputs();
        #1;
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("rst_s_stb", 64'(s_stb_o), 64'(0));
        chk("rst_stall", 64'(m_stall_o), 64'(4'b1111));
        chk("rst_ack_err", 64'({m_ack_o, m_err_o}), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        m_cyc_i = 4'b0001;
        @(negedge clk_i);
        #1;
        chk("t1_grant", 64'(grant_o), 64'(4'b0001));
        chk("t1_busy", 64'(busy_o), 64'(1));
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            m_stb_i[0] = (i < 3);
            s_ack_i    = (i >= 1 && i <= 3);
            #1;
            if (m_ack_o[0]) ack_cnt++;
            @(negedge clk_i);
        end
        chk("t1_ack_pulses", 64'(ack_cnt), 64'(3));
        m_cyc_i = '0;
        #1;
        chk("t1_busy_hold", 64'(busy_o), 64'(1));
        chk("t1_s_cyc_drop", 64'(s_cyc_o), 64'(0));
        @(negedge clk_i);
        #1;
        chk("t1_busy_fall", 64'(busy_o), 64'(0));

        // Arbitration vector table, rr pointer carried across entries
        do_reset();
        for (int v = 0; v < 10; v++) begin
            @(negedge clk_i);
            m_cyc_i = vecs[v].cyc;
            @(negedge clk_i);
            #1;
            chk($sformatf("vec%0d_grant", v), 64'(grant_o), 64'(vecs[v].exp_grant));
            m_cyc_i = '0;
            @(negedge clk_i);
        end
        // Request dropping before the grant registers is still granted for one cycle
        m_cyc_i = 4'b0100;
        @(negedge clk_i);
        m_cyc_i = '0;
        #1;
        chk("drop_early_grant", 64'(grant_o), 64'(4'b0100));
        @(negedge clk_i);
        #1;
        chk("drop_early_idle", 64'(grant_o), 64'(0));

        // All four masters request at once, one write each
        do_reset();
        m_cyc_i = '1;
        m_we_i  = '1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk_i);
            #1;
            chk($sformatf("t2_grant%0d", k), 64'(grant_o), 64'(1) << k);
            m_stb_i[k] = 1'b1;
            @(negedge clk_i);
            m_stb_i[k] = 1'b0;
            s_ack_i    = 1'b1;
            #1;
            chk($sformatf("t2_ack%0d", k), 64'(m_ack_o), 64'(1) << k);
            @(negedge clk_i);
            s_ack_i    = 1'b0;
            m_cyc_i[k] = 1'b0;
            @(negedge clk_i);
            #1;
            chk($sformatf("t2_gap%0d", k), 64'(s_cyc_o), 64'(0));
        end
        m_cyc_i[0] = 1'b1;
        @(negedge clk_i);
        #1;
        chk("t2_rerequest", 64'(grant_o), 64'(4'b0001));
        m_cyc_i = '0;
        @(negedge clk_i);

        // Outstanding limit: six strobes, no acks
        do_reset();
        m_cyc_i = 4'b0100;
        @(negedge clk_i);
        #1;
        chk("t3_grant", 64'(grant_o), 64'(4'b0100));
        m_stb_i[2] = 1'b1;
        stb_cnt = 0;
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (s_stb_o) stb_cnt++;
            if (m_stall_o[2]) stall_cnt++;
            @(negedge clk_i);
        end
        chk("t3_accepts", 64'(stb_cnt), 64'(4));
        chk("t3_stall_full", 64'(stall_cnt), 64'(2));
        chk("t3_stall_all", 64'(m_stall_o), 64'(4'b1111));
        m_stb_i = '0;
        m_cyc_i = '0;
        repeat (2) @(negedge clk_i);

        // Slave timeout with one outstanding request
        do_reset();
        m_cyc_i = 4'b1010;
        @(negedge clk_i);
        #1;
        chk("t4_grant", 64'(grant_o), 64'(4'b0010));
        m_stb_i[1] = 1'b1;
        j = 0;
        found = 0;
        while (!found && j < 200) begin
            @(negedge clk_i);
            j++;
            m_stb_i = '0;
            #1;
            if (m_err_o[1]) found = 1;
        end
        chk("t4_err_cycle", 64'(j), 64'(65));
        chk("t4_err_vec", 64'(m_err_o), 64'(4'b0010));
        chk("t4_err_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("t4_err_ack", 64'(m_ack_o), 64'(0));
        @(negedge clk_i);
        #1;
        chk("t4_err_single", 64'(m_err_o), 64'(0));
        chk("t4_hold_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("t4_hold_stall", 64'(m_stall_o), 64'(4'b1111));
        s_ack_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("t4_hold_ignore_ack", 64'(m_ack_o), 64'(0));
        chk("t4_hold_grant", 64'(grant_o), 64'(4'b0010));
        s_ack_i = 1'b0;
        m_cyc_i[1] = 1'b0;
        @(negedge clk_i);
        #1;
        chk("t4_idle", 64'(grant_o), 64'(0));
        @(negedge clk_i);
        #1;
        chk("t4_next_master", 64'(grant_o), 64'(4'b1000));
        m_cyc_i = '0;
        @(negedge clk_i);

        // Simultaneous ack and err
        do_reset();
        m_cyc_i = 4'b0011;
        nonown  = '0;
        @(negedge clk_i);
        #1;
        chk("t5_grant", 64'(grant_o), 64'(4'b0001));
        m_stb_i[0] = 1'b1;
        @(negedge clk_i);
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        #1;
        chk("t5_err_wins", 64'(m_err_o), 64'(4'b0001));
        chk("t5_no_ack", 64'(m_ack_o), 64'(0));
        nonown = nonown | ((m_ack_o | m_err_o) & 4'b1110);
        @(negedge clk_i);
        m_stb_i = '0;
        s_err_i = 1'b0;
        #1;
        chk("t5_ack_only", 64'({m_ack_o, m_err_o}), 64'({4'b0001, 4'b0000}));
        nonown = nonown | ((m_ack_o | m_err_o) & 4'b1110);
        @(negedge clk_i);
        s_ack_i = 1'b0;
        s_err_i = 1'b1;
        #1;
        chk("t5_err_zero_outst", 64'(m_err_o), 64'(4'b0001));
        nonown = nonown | ((m_ack_o | m_err_o) & 4'b1110);
        chk("t5_nonowner_quiet", 64'(nonown), 64'(0));
        s_err_i = 1'b0;
        m_cyc_i = '0;
        repeat (2) @(negedge clk_i);

        // Asynchronous reset in the middle of a burst
        do_reset();
        m_cyc_i = 4'b1000;
        @(negedge clk_i);
        #1;
        chk("t6_grant", 64'(grant_o), 64'(4'b1000));
        m_stb_i[3] = 1'b1;
        repeat (2) @(negedge clk_i);
        m_stb_i = '0;
        m_cyc_i = 4'b1001;
        s_ack_i = 1'b1;
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_s_cyc", 64'({s_cyc_o, s_stb_o}), 64'(0));
        chk("t6_grant_busy", 64'({grant_o, busy_o}), 64'(0));
        chk("t6_resp", 64'({m_ack_o, m_err_o}), 64'(0));
        chk("t6_stall", 64'(m_stall_o), 64'(4'b1111));
        s_ack_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("t6_regrant", 64'(grant_o), 64'(4'b0001));
        m_cyc_i = '0;

        // Randomized traffic against the reference model
        do_reset();
        mo_owner = 0; mo_rr = 0; mo_outs = 0; mo_silent = 0;
        mo_owned = 0; mo_terr = 0; mo_hold = 0;
        hang = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (hang == 0 && $urandom_range(299) == 0) hang = 90;
            for (int k = 0; k < N; k++) begin
                if (m_cyc_i[k]) begin
                    if (hang == 0 && $urandom_range(11) == 0) m_cyc_i[k] = 1'b0;
                end else if ($urandom_range(5) == 0) begin
                    m_cyc_i[k] = 1'b1;
                end
                m_stb_i[k] = m_cyc_i[k] & ($urandom_range(1) == 1);
                m_we_i[k]  = ($urandom_range(1) == 1);
            end
            m_adr_i = {$urandom, $urandom};
            m_dat_i = {$urandom, $urandom, $urandom, $urandom};
            m_sel_i = 16'($urandom);
            if (hang > 0) begin
                hang--;
                s_ack_i = 1'b0;
                s_err_i = 1'b0;
            end else begin
                s_ack_i = ($urandom_range(2) == 0);
                s_err_i = ($urandom_range(19) == 0);
            end
            s_stall_i = ($urandom_range(4) == 0);
            s_dat_i   = $urandom;
            #1;

            e_grant = '0; e_ack = '0; e_err = '0; e_stall = '1;
            e_busy = 1'b0; e_scyc = 1'b0; e_sstb = 1'b0;
            o = mo_owner;
            full = (mo_outs == MAXO);
            acc = 0;
            resp = 0;
            if (mo_owned) begin
                e_grant[o] = 1'b1;
                e_busy     = 1'b1;
            end
            if (mo_owned && !mo_terr && !mo_hold) begin
                e_scyc     = m_cyc_i[o];
                e_sstb     = m_stb_i[o] && !full;
                e_stall[o] = s_stall_i || full;
                e_ack[o]   = m_cyc_i[o] && s_ack_i && !s_err_i;
                e_err[o]   = m_cyc_i[o] && s_err_i;
                acc        = m_stb_i[o] && !(s_stall_i || full);
                resp       = m_cyc_i[o] && (s_ack_i || s_err_i);
            end
            if (mo_owned && mo_terr) e_err[o] = 1'b1;

            chk("rnd_grant", 64'(grant_o), 64'(e_grant));
            chk("rnd_busy", 64'(busy_o), 64'(e_busy));
            chk("rnd_s_cyc", 64'(s_cyc_o), 64'(e_scyc));
            chk("rnd_s_stb", 64'(s_stb_o), 64'(e_sstb));
            chk("rnd_ack", 64'(m_ack_o), 64'(e_ack));
            chk("rnd_err", 64'(m_err_o), 64'(e_err));
            chk("rnd_stall", 64'(m_stall_o), 64'(e_stall));
            chk("rnd_rdata", 64'(m_dat_o), 64'(s_dat_i));
            if (e_scyc) begin
                chk("rnd_adr", 64'(s_adr_o), 64'(m_adr_i[o*AW +: AW]));
                chk("rnd_wdat", 64'(s_dat_o), 64'(m_dat_i[o*DW +: DW]));
                chk("rnd_we_sel", 64'({s_we_o, s_sel_o}), 64'({m_we_i[o], m_sel_i[o*SW +: SW]}));
            end

            if (!mo_owned) begin
                for (int k = 0; k < N; k++) begin
                    if (!mo_owned && m_cyc_i[(mo_rr + k) % N]) begin
                        mo_owned = 1;
                        mo_owner = (mo_rr + k) % N;
                    end
                end
                mo_outs = 0;
                mo_silent = 0;
            end else if (mo_terr) begin
                mo_terr = 0;
                mo_hold = 1;
                mo_outs = 0;
            end else if (mo_hold) begin
                if (!m_cyc_i[o]) begin
                    mo_owned = 0;
                    mo_hold  = 0;
                    mo_rr    = (o + 1) % N;
                end
            end else if (!m_cyc_i[o]) begin
                mo_owned  = 0;
                mo_rr     = (o + 1) % N;
                mo_outs   = 0;
                mo_silent = 0;
            end else begin
                if (resp || mo_outs == 0) begin
                    mo_silent = 0;
                end else if (mo_silent == TO - 1) begin
                    mo_silent = 0;
                    mo_terr   = 1;
                end else begin
                    mo_silent++;
                end
                mo_outs = mo_outs + int'(acc) - int'(resp);
                if (mo_outs < 0) mo_outs = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Round-robin arbiter that shares one pipelined Wishbone slave among NUM_MASTERS masters. It sits between the master ports and the register-file slave.
- Grants bus ownership per Wishbone cycle (cyc held high).
- Tracks outstanding pipelined requests and holds the grant until the owner drops cyc.
- Generates a bus error on slave response timeout, so a hung slave cannot lock out other masters.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_WIDTH, 16, address width
DATA_WIDTH, 32, data width
GRANULE, 8, bits per select lane; SEL_WIDTH = DATA_WIDTH/GRANULE
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests
TIMEOUT, 64, cycles without ack/err while outstanding>0 before a forced error

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-low
m_cyc_i  in  NUM_MASTERS  per-master cyc
m_stb_i  in  NUM_MASTERS  per-master stb
m_we_i  in  NUM_MASTERS  per-master we
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*AW +: AW]
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
m_dat_o  out  DATA_WIDTH  read data broadcast to all masters (= s_dat_i)
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master err
m_stall_o  out  NUM_MASTERS  per-master stall
s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
s_adr_o  out  ADDR_WIDTH  to slave
s_dat_o  out  DATA_WIDTH  to slave
s_sel_o  out  SEL_WIDTH  to slave
s_dat_i  in  DATA_WIDTH  from slave
s_ack_i, s_err_i, s_stall_i  in  1 each  from slave
grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
busy_o  out  1  high in any state other than IDLE

Behaviour:
Reset (rst_i=0, asynchronous):
- State=IDLE, rr pointer=0, outstanding=0, timer=0.
- s_cyc_o=0, s_stb_o=0, grant_o=0, m_ack_o=0, m_err_o=0, m_stall_o=all 1s, busy_o=0.
- Reset mid-transaction drops s_cyc_o immediately; no responses are forwarded afterwards.

IDLE:
- All masters see stall=1.
- If any m_cyc_i is high, pick the first requester at or above the rr pointer, with wrap.
- Register that pick into grant_o and go to GRANT. Arbitration latency is 1 cycle.

GRANT (owner g):
- s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g] & (outstanding<MAX_OUTSTANDING).
- s_we/adr/dat/sel_o are muxed from g. Non-owner masters: stall=1, ack=0, err=0.
- m_stall_o[g] = s_stall_i | (outstanding==MAX_OUTSTANDING).
- Accept = m_stb_i[g] & !m_stall_o[g]. Response = s_ack_i | s_err_i.
- outstanding += accept − response, all in the same cycle. Outstanding never underflows: a response with outstanding=0 is forwarded and the count stays 0.
- m_ack_o[g] = s_ack_i & !s_err_i; m_err_o[g] = s_err_i. Err wins over ack, so ack and err are never high together. Responses pass through combinationally.
- When m_cyc_i[g] falls: go to IDLE, set rr pointer=(g+1) mod NUM_MASTERS, clear outstanding. Late slave responses are dropped.
- Timer: cleared on any response or when outstanding=0, else increments. When timer==TIMEOUT−1 with no response that cycle, go to TERR.

TERR:
- One cycle. m_err_o[g]=1, s_cyc_o=0, s_stb_o=0, outstanding cleared. Then go to HOLD.

HOLD:
- s_cyc_o=0, m_stall_o[g]=1, slave responses ignored. When m_cyc_i[g]=0, go to IDLE and advance the rr pointer.

Boundaries:
- s_cyc_o is low for at least one cycle between owners.
- Simultaneous requests are resolved solely by the rr pointer.
- A single requester is re-granted every time it re-requests.
- A request that drops before the grant registers still gets the grant. That master sees cyc low next cycle, so the arbiter returns to IDLE.

Test Plan:
1. Reset, then m_cyc_i=0001 with 3 pipelined stb, slave acks each 1 cycle later -> grant_o=0001 after 1 cycle; 3 m_ack_o[0] pulses; busy_o falls 1 cycle after cyc drops.
2. m_cyc_i=1111 held from the same cycle, each master does 1 write -> grant order 0,1,2,3, with s_cyc_o low ≥1 cycle between grants; then master 0 re-requests and wins.
3. Master 2 issues 6 stb, slave never stalls and withholds ack -> s_stb_o high for exactly 4 accepts; m_stall_o[2]=1 while outstanding=4.
4. Owner has 1 outstanding and slave silent for 64 cycles -> single-cycle m_err_o[g]=1, s_cyc_o=0, HOLD until cyc drops, then the next master is granted.
5. s_ack_i and s_err_i high in the same cycle -> m_err_o[g]=1, m_ack_o[g]=0; non-owner ack/err remain 0 throughout.
6. rst_i asserted low mid-burst with 2 outstanding -> all outputs take reset values immediately; after release, master 0 is granted first.
